// File: rtl/lcm_seq_if.sv
// Request/response bundle between the GCD stage side and the LCM sequencer.
// The requester drives start and the operands; the sequencer returns status and result.
interface lcm_seq_if #(
    parameter int unsigned W = 7
);
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     G;
    logic             busy;
    logic             done;
    logic             err;
    logic [2*W-1:0]   LCM;

    modport master (output start, A, B, G, input busy, done, err, LCM);
    modport slave  (input start, A, B, G, output busy, done, err, LCM);
endinterface

// File: rtl/lcm_seq.sv
// Sequential LCM unit: restoring divide A/G, then shift-add multiply by B.
// Error when G is zero or leaves a remainder; zero operands short-circuit.
module lcm_seq #(
    parameter int unsigned W = 7
) (
    input  logic      clk,
    input  logic      rst_n,
    lcm_seq_if.slave  bus
);
    localparam int unsigned LW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, DIV, MUL, FIN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    g_q, g_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [LW-1:0]   b_q, b_d;
    logic [LW-1:0]   acc_q, acc_d;
    logic            err_pend_q, err_pend_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [LW-1:0]   lcm_q, lcm_d;
    logic [W+1:0]    trial;
    logic            last_iter;

    // Next-state and datapath; FIN is the single place a result is published.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        g_d        = g_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        b_d        = b_q;
        acc_d      = acc_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        lcm_d      = lcm_q;
        done_d     = 1'b0;
        last_iter  = (cnt_q == CW'(W - 1));
        trial      = {rem_q, a_q[W-1]} - {2'b00, g_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d        = bus.A;
                    g_d        = bus.G;
                    b_d        = LW'(bus.B);
                    rem_d      = '0;
                    quo_d      = '0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                    if (bus.A == '0 || bus.B == '0) begin
                        state_d = FIN;
                    end else if (bus.G == '0) begin
                        err_pend_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // Negative trial (MSB set) means restore: keep the shifted remainder.
                rem_d = trial[W+1] ? {rem_q[W-1:0], a_q[W-1]} : trial[W:0];
                quo_d = {quo_q[W-2:0], ~trial[W+1]};
                a_d   = {a_q[W-2:0], 1'b0};
                cnt_d = last_iter ? '0 : cnt_q + CW'(1);
                if (last_iter) begin
                    if (rem_d != '0) begin
                        err_pend_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (quo_q[0]) acc_d = acc_q + b_q;
                b_d   = {b_q[LW-2:0], 1'b0};
                quo_d = {1'b0, quo_q[W-1:1]};
                cnt_d = last_iter ? '0 : cnt_q + CW'(1);
                if (last_iter) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                lcm_d   = err_pend_q ? '0 : acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            g_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lcm_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            g_q        <= g_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            lcm_q      <= lcm_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.LCM  = lcm_q;
endmodule

// File: tb/tb_lcm_seq.sv
// Directed and randomized checks of lcm_seq against an arithmetic LCM/latency model.
module tb_lcm_seq;
    localparam int unsigned W = 7;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lcm_seq_if #(.W(W)) bus ();

    lcm_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd(input int x, input int y);
        int a = x;
        int b = y;
        while (b != 0) begin
            int t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Expected result and cycles from start edge to the done cycle.
    task automatic model(input int a, input int b, input int g,
                         output int lcm, output int err, output int lat);
        if (a == 0 || b == 0) begin
            lcm = 0; err = 0; lat = 1;
        end else if (g == 0) begin
            lcm = 0; err = 1; lat = 1;
        end else if (a % g != 0) begin
            lcm = 0; err = 1; lat = W + 1;
        end else begin
            lcm = (a / g) * b; err = 0; lat = 2 * W + 1;
        end
    endtask

    // Called just after a rising edge; the next edge is edge 0.
    task automatic launch(input int a, input int b, input int g);
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.G     = W'(g);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns in the done cycle (or after the cycle budget).
    task automatic run_op(input int a, input int b, input int g,
                          input bit disturb, input string tag);
        int  exp_lcm, exp_err, exp_lat;
        int  n;
        bit  busy_ok;
        model(a, b, g, exp_lcm, exp_err, exp_lat);
        launch(a, b, g);
        n = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (disturb) begin
                bus.start = 1'($urandom);
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
                bus.G     = W'($urandom);
            end
        end
        bus.start = 1'b0;
        chk({tag, " done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " lcm"}, 32'(bus.LCM), 32'(exp_lcm));
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        int   exp_lcm, exp_err, exp_lat;
        logic [2*W-1:0] held_lcm;
        logic held_err;
        bit   saw_done;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.G     = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset err",  32'(bus.err),  32'd0);
        chk("reset lcm",  32'(bus.LCM),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(12, 18, 6, 1'b0, "basic");
        held_lcm = bus.LCM;
        held_err = bus.err;
        @(posedge clk);
        #1;
        chk("done one cycle", 32'(bus.done), 32'd0);
        chk("lcm holds", 32'(bus.LCM), 32'(held_lcm));
        chk("err holds", 32'(bus.err), 32'(held_err));

        run_op(127, 126, 1, 1'b0, "max_g1");
        run_op(127, 127, 127, 1'b0, "max_same");
        run_op(0, 5, 5, 1'b0, "a_zero");
        run_op(9, 6, 0, 1'b0, "g_zero");
        run_op(12, 18, 4, 1'b0, "g4_divides");
        run_op(12, 18, 5, 1'b0, "bad_gcd");
        run_op(4, 6, 2, 1'b0, "after_bad");
        run_op(5, 9, 7, 1'b0, "g_gt_a");

        run_op(12, 18, 6, 1'b1, "disturbed");
        run_op(7, 0, 3, 1'b0, "b2b_fast");
        run_op(10, 15, 5, 1'b0, "b2b_norm");

        // Abort in the multiply phase.
        launch(12, 18, 6);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort err",  32'(bus.err),  32'd0);
        chk("abort lcm",  32'(bus.LCM),  32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort no done", 32'(saw_done), 32'd0);
        run_op(8, 12, 4, 1'b0, "post_reset");

        for (int i = 0; i < 30; i++) begin
            int a, b, g;
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, 127));
            else                           g = gcd(a, b);
            run_op(a, b, g, 1'($urandom_range(0, 1)), $sformatf("rand%0d a=%0d b=%0d g=%0d", i, a, b, g));
        end

        model(1, 1, 1, exp_lcm, exp_err, exp_lat);
        chk("model sanity", 32'(exp_lat), 32'(2 * W + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
